regfile_mp: RTL

//  Parametrised 2-read/2-write integer register file with load scoreboard for the RV32I pipeline.

---
 rtl/regfile_mp.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write integer register file with per-register load busy bits.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we_a,
    input  logic [AW-1:0]   wa_a,
    input  logic [XLEN-1:0] wd_a,
    input  logic            we_b,
    input  logic [AW-1:0]   wa_b,
    input  logic [XLEN-1:0] wd_b,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_addr
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREGS);
    endfunction

    // Reg 0 is hardwired when ZERO_REG is set; out-of-range slots never exist.
    function automatic logic writable(input logic [AW-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we_b && writable(wa_b)) begin
            regs_d[wa_b] = wd_b;
            busy_d[wa_b] = 1'b0;
        end
        if (we_a && writable(wa_a)) begin
            regs_d[wa_a] = wd_a;
        end
        if (busy_set && writable(busy_addr)) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = writable(a) ? regs_q[a] : '0;
`ifdef REGFILE_BYPASS_EN
        if (we_b && writable(wa_b) && (wa_b == a)) v = wd_b;
        if (we_a && writable(wa_a) && (wa_a == a)) v = wd_a;
`endif
        return v;
    endfunction

    function automatic logic busy_port(input logic [AW-1:0] a);
        logic v;
        v = in_range(a) ? busy_q[a] : 1'b0;
`ifdef REGFILE_BYPASS_EN
        // A re-issued load to the same register keeps it busy.
        if (we_b && (wa_b == a) && !(busy_set && (busy_addr == a))) v = 1'b0;
`endif
        return v;
    endfunction

    assign rd1   = rd_port(ra1);
    assign rd2   = rd_port(ra2);
    assign busy1 = busy_port(ra1);
    assign busy2 = busy_port(ra2);

endmodule
